// File: rtl/bcd_digit_streamer.sv
// Captures NUM_DIGITS packed BCD digits on start and streams one decoded digit per valid/ready
// handshake. Defining BCD_STREAM_ERRCNT_EN adds err_count / first_err_idx / first_err_vld outputs.
module bcd_digit_streamer #(
  parameter int NUM_DIGITS = 300,
  parameter int MSD_FIRST  = 0,
  parameter int SUB_VALUE  = 0,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int CNT_W = $clog2(NUM_DIGITS + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [4*NUM_DIGITS-1:0] bcd,
  output logic [3:0]              dec,
  output logic                    dec_valid,
  input  logic                    dec_ready,
  output logic                    dec_err,
  output logic                    dec_last,
  output logic                    busy,
  output logic                    done
`ifdef BCD_STREAM_ERRCNT_EN
  ,
  output logic [CNT_W-1:0]        err_count,
  output logic [IDX_W-1:0]        first_err_idx,
  output logic                    first_err_vld
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [IDX_W-1:0]        r_idx;
  logic [IDX_W-1:0]        w_idx_nxt;
  logic [IDX_W-1:0]        w_phys;
  logic                    w_capture;
  logic                    w_load;
  logic                    w_valid_nxt;
  logic                    w_done_nxt;
  logic                    w_hs;
  logic [4*NUM_DIGITS-1:0] w_src;
  logic [3:0]              w_digit;
  logic [4:0]              w_decoded;

  // Returns {err, value}: out-of-range digits are replaced by SUB_VALUE and flagged
  function automatic logic [4:0] decode_digit(input logic [3:0] d);
    if (d > 4'd9) begin
      return {1'b1, 4'(SUB_VALUE)};
    end else begin
      return {1'b0, d};
    end
  endfunction

  assign w_hs = dec_valid & dec_ready;

  // The digit for the next presentation is decoded ahead so the outputs can be registered
  assign w_src     = w_capture ? bcd : r_shadow;
  assign w_phys    = (MSD_FIRST != 0) ? (LAST_IDX - w_idx_nxt) : w_idx_nxt;
  assign w_digit   = w_src[{w_phys, 2'b00} +: 4];
  assign w_decoded = decode_digit(w_digit);

  // Next-state and control decode
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_capture   = 1'b0;
    w_load      = 1'b0;
    w_valid_nxt = dec_valid;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_idx_nxt   = '0;
          w_capture   = 1'b1;
          w_load      = 1'b1;
          w_valid_nxt = 1'b1;
        end else begin
          w_idx_nxt   = '0;
          w_valid_nxt = 1'b0;
        end
      end
      ST_RUN: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = '0;
          w_valid_nxt = 1'b0;
        end else if (w_hs) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = ST_DONE;
            w_valid_nxt = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_load      = 1'b1;
          end
        end else begin
          w_valid_nxt = 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
        w_valid_nxt = 1'b0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and stream index registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Shadow capture and registered stream outputs; digit fields only move on a load
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_shadow  <= '0;
      dec       <= 4'd0;
      dec_err   <= 1'b0;
      dec_last  <= 1'b0;
      dec_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (w_capture) begin
        r_shadow <= bcd;
      end
      if (w_load) begin
        dec      <= w_decoded[3:0];
        dec_err  <= w_decoded[4];
        dec_last <= (w_idx_nxt == LAST_IDX);
      end
      dec_valid <= w_valid_nxt;
      busy      <= (w_state_nxt != ST_IDLE);
      done      <= w_done_nxt;
    end
  end

`ifdef BCD_STREAM_ERRCNT_EN
  logic w_err_acc;
  assign w_err_acc = (r_state == ST_RUN) & w_hs & ~abort & dec_err;

  // Error statistics over accepted digits, cleared by each accepted start
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_vld <= 1'b0;
    end else if (w_capture) begin
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_vld <= 1'b0;
    end else if (w_err_acc) begin
      if (err_count != CNT_W'(NUM_DIGITS)) begin
        err_count <= err_count + CNT_W'(1);
      end
      if (!first_err_vld) begin
        first_err_idx <= r_idx;
        first_err_vld <= 1'b1;
      end
    end
  end
`endif

endmodule
